ma_stage_ctrl: RTL and testbench

Memory-access stage controller. It consumes the EX/MA pipeline register outputs and runs loads and stores against a data memory with a req/ack handshake. It stalls the front of the pipeline while an access is outstanding, and registers the write-back bundle for the MA/WB boundary.

---
 rtl/ma_stage_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ma_stage_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage control: req/ack data-memory sequencing, front-end
// stall, and the MA/WB write-back register.
// Inputs:  clkIn, resetIn, ctrSignalsIn, ResultIn, DataIn, rdIn,
//          memAckIn, memRdataIn.
// Outputs: memReqOut, memWeOut, memAddrOut, memWdataOut, stallOut,
//          misalignOut, errOut, wbValidOut, wbRegWriteOut, wbRdOut,
//          wbDataOut.
// Optional: MA_TIMEOUT_EN aborts a REQ after TIMEOUT_CYCLES cycles.
module ma_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [7:0]  ctrSignalsIn,
  input  logic [31:0] ResultIn,
  input  logic [31:0] DataIn,
  input  logic [4:0]  rdIn,
  output logic        memReqOut,
  output logic        memWeOut,
  output logic [31:0] memAddrOut,
  output logic [31:0] memWdataOut,
  input  logic        memAckIn,
  input  logic [31:0] memRdataIn,
  output logic        stallOut,
  output logic        misalignOut,
  output logic        errOut,
  output logic        wbValidOut,
  output logic        wbRegWriteOut,
  output logic [4:0]  wbRdOut,
  output logic [31:0] wbDataOut
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_n;

  logic mem_rd, mem_wr, reg_wr, mem2reg;
  logic memop, aligned, rd_nz, go;
  logic stall_raw;
  logic tmo, sup;
  logic [31:0] rdata_q;

  assign mem_rd  = ctrSignalsIn[0];
  assign mem_wr  = ctrSignalsIn[1];
  assign reg_wr  = ctrSignalsIn[2];
  assign mem2reg = ctrSignalsIn[3];
  assign memop   = mem_rd | mem_wr;
  assign aligned = (ResultIn[1:0] == 2'b00);
  assign rd_nz   = (rdIn != 5'd0);
  assign go      = memop & aligned;

  logic unused_ctr;
  assign unused_ctr = ^ctrSignalsIn[7:4];

  always_comb begin
    state_n   = state;
    stall_raw = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (go) begin
          stall_raw = 1'b1;
          state_n   = REQ;
        end
      end
      (state == REQ): begin
        stall_raw = 1'b1;
        if (memAckIn || tmo) state_n = DONE;
      end
      (state == DONE): state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A held reset never stalls the pipe, even with a memop waiting.
  assign stallOut = stall_raw & resetIn;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state         <= IDLE;
      memReqOut     <= 1'b0;
      memWeOut      <= 1'b0;
      memAddrOut    <= '0;
      memWdataOut   <= '0;
      misalignOut   <= 1'b0;
      wbValidOut    <= 1'b0;
      wbRegWriteOut <= 1'b0;
      wbRdOut       <= '0;
      wbDataOut     <= '0;
      rdata_q       <= '0;
    end else begin
      state       <= state_n;
      wbValidOut  <= 1'b0;
      misalignOut <= (state == IDLE) & memop & ~aligned;
      unique case (1'b1)
        (state == IDLE): begin
          if (go) begin
            memReqOut   <= 1'b1;
            memWeOut    <= mem_wr;
            memAddrOut  <= {ResultIn[31:2], 2'b00};
            memWdataOut <= DataIn;
          end else begin
            wbValidOut    <= 1'b1;
            wbRegWriteOut <= reg_wr & rd_nz & ~memop;
            wbRdOut       <= rdIn;
            wbDataOut     <= ResultIn;
          end
        end
        (state == REQ): begin
          if (memAckIn) begin
            memReqOut <= 1'b0;
            rdata_q   <= memRdataIn;
          end else if (tmo) begin
            memReqOut <= 1'b0;
            rdata_q   <= '0;
          end
        end
        (state == DONE): begin
          wbValidOut    <= 1'b1;
          wbRegWriteOut <= reg_wr & rd_nz & ~sup;
          wbRdOut       <= rdIn;
          wbDataOut     <= mem2reg ? rdata_q : ResultIn;
        end
        default: ;
      endcase
    end
  end

`ifdef MA_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          err_q, sup_q;

  // cnt holds (REQ cycles elapsed - 1); fires on the last allowed cycle.
  assign tmo    = (state == REQ) & ~memAckIn & (cnt == LAST);
  assign sup    = sup_q;
  assign errOut = err_q;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt   <= '0;
      err_q <= 1'b0;
      sup_q <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else if (state == REQ) cnt <= cnt + 1'b1;
      if (tmo) begin
        err_q <= 1'b1;
        sup_q <= 1'b1;
      end else if (state == DONE) begin
        sup_q <= 1'b0;
      end
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo    = 1'b0;
  assign sup    = 1'b0;
  assign errOut = 1'b0;
`endif

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// Self-checking bench for ma_stage_ctrl: directed cases then random
// instructions against a per-instruction transaction model.
module tb_ma_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ctrl;
  logic [31:0] result, din, rdata;
  logic [4:0]  rdi;
  logic        ack;
  logic        req, we, stall, mis, err, wbv, wbrw;
  logic [31:0] addr, wdata, wbd;
  logic [4:0]  wbrd;

  int total = 0;
  int bad   = 0;

  logic [4:0]  p_rd;
  logic [31:0] p_data;

  always #5 clk = ~clk;

  ma_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clkIn(clk),
    .resetIn(rst_n),
    .ctrSignalsIn(ctrl),
    .ResultIn(result),
    .DataIn(din),
    .rdIn(rdi),
    .memReqOut(req),
    .memWeOut(we),
    .memAddrOut(addr),
    .memWdataOut(wdata),
    .memAckIn(ack),
    .memRdataIn(rdata),
    .stallOut(stall),
    .misalignOut(mis),
    .errOut(err),
    .wbValidOut(wbv),
    .wbRegWriteOut(wbrw),
    .wbRdOut(wbrd),
    .wbDataOut(wbd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction from presentation to retirement. Expected values
  // come from the instruction-level rules: aligned memops stall for
  // 1 + lat cycles and retire one cycle after the ack.
  task automatic run(input logic [7:0] c, input logic [31:0] res,
                     input logic [31:0] d, input logic [4:0] rd,
                     input int lat, input logic [31:0] rdv);
    logic        memop, alg, rw;
    logic [31:0] expd;
    ctrl = c; result = res; din = d; rdi = rd;
    ack = 1'b0; rdata = $urandom;
    #1;
    memop = c[0] | c[1];
    alg   = (res[1:0] == 2'b00);
    if (memop && alg) begin
      chk("stall_setup", stall, 1);
      chk("req_setup", req, 0);
      tick();
      for (int i = 1; i <= lat; i++) begin
        chk("stall_req", stall, 1);
        chk("req_hi", req, 1);
        chk("we", we, c[1]);
        chk("addr", addr, {res[31:2], 2'b00});
        chk("wdata", wdata, d);
        chk("wbv_stall", wbv, 0);
        chk("wbrd_hold", wbrd, p_rd);
        chk("wbd_hold", wbd, p_data);
        if (i == lat) begin
          ack = 1'b1;
          rdata = rdv;
        end
        tick();
        ack = 1'b0;
        rdata = $urandom;
      end
      chk("stall_done", stall, 0);
      chk("req_done", req, 0);
      chk("wbv_done", wbv, 0);
      expd = c[3] ? rdv : res;
      rw = c[2] && (rd != 0);
      tick();
      chk("mis_none", mis, 0);
    end else begin
      chk("stall_none", stall, 0);
      tick();
      expd = res;
      rw = c[2] && (rd != 0) && !memop;
      chk("mis", mis, memop);
      chk("req_none", req, 0);
    end
    chk("wbv", wbv, 1);
    chk("wbrw", wbrw, rw);
    chk("wbrd", wbrd, rd);
    chk("wbd", wbd, expd);
    chk("err", err, 0);
    p_rd = rd;
    p_data = expd;
  endtask

  initial begin
    rst_n = 1'b0; ctrl = '0; result = '0; din = '0; rdi = '0;
    ack = 1'b0; rdata = '0; p_rd = '0; p_data = '0;
    #12;
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mis", mis, 0);
    chk("rst_err", err, 0);
    chk("rst_wbv", wbv, 0);
    chk("rst_wbrw", wbrw, 0);
    chk("rst_wbrd", wbrd, 0);
    chk("rst_wbd", wbd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'h04, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
    run(8'h0D, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hCAFE_F00D);
    run(8'h02, 32'h0000_0204, 32'hA5A5_A5A5, 5'd3, 1, 32'h1111_2222);
    run(8'h0D, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h0);
    run(8'h04, 32'h0000_0042, 32'h0, 5'd9, 0, 32'h0);
    run(8'h0D, 32'h0000_0100, 32'h0, 5'd0, 2, 32'h5555_AAAA);
    run(8'h00, 32'h0000_0077, 32'h0, 5'd6, 0, 32'h0);
    run(8'h07, 32'h0000_0308, 32'h1357_9BDF, 5'd4, 2, 32'h2468_ACE0);

    // Ack while idle must leave no trace.
    ctrl = 8'h00; result = 32'h55; rdi = 5'd4;
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_ack_stall", stall, 0);
    tick();
    ack = 1'b0;
    chk("idle_ack_wbv", wbv, 1);
    chk("idle_ack_wbrw", wbrw, 0);
    chk("idle_ack_wbd", wbd, 32'h55);
    chk("idle_ack_req", req, 0);
    p_rd = 5'd4; p_data = 32'h55;

    // Reset in the middle of an outstanding load.
    ctrl = 8'h0D; result = 32'h400; rdi = 5'd8;
    tick();
    tick();
    chk("pre_rst_req", req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wbv", wbv, 0);
    chk("mid_rst_wbrw", wbrw, 0);
    chk("mid_rst_wbrd", wbrd, 0);
    chk("mid_rst_wbd", wbd, 0);
    ack = 1'b1; rdata = 32'h0BAD_0BAD;
    tick();
    ack = 1'b0;
    chk("rst_ack_wbv", wbv, 0);
    ctrl = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    p_rd = '0; p_data = '0;

    for (int n = 0; n < 60; n++) begin
      logic [7:0]  c;
      logic [31:0] res;
      c = 8'($urandom);
      res = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      run(c, res, $urandom, 5'($urandom), $urandom_range(1, 3),
          $urandom);
    end

`ifdef MA_TIMEOUT_EN
    ctrl = 8'h0D; result = 32'h300; rdi = 5'd9; ack = 1'b0;
    #1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("tmo_req", req, 1);
      tick();
    end
    chk("tmo_req_drop", req, 0);
    chk("tmo_stall", stall, 0);
    chk("tmo_err", err, 1);
    tick();
    chk("tmo_wbv", wbv, 1);
    chk("tmo_wbrw", wbrw, 0);
    chk("tmo_wbd", wbd, 0);
    ctrl = 8'h00; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("tmo_err_sticky", err, 1);
    chk("tmo_idle_req", req, 0);
    chk("tmo_idle_wbv", wbv, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
